// File: rtl/spi_host_master.sv
// -----------------------------------------------------------------------------
// spi_host_master
//
// SPI initiator, MSB first, word oriented. Drives an external SPI slave (for
// example a stepper-driver configuration port) from the kstep command logic.
// Chip select stays low across a burst of words until a word flagged
// tx_last has finished, then is held for a short hold time and released for
// a minimum guard time before the next burst can start.
//
// Optional feature (compile-time macro KSTEP_SPI_MODE3_EN):
//   undefined : SPI mode 0, spi_sclk idles low.
//   defined   : SPI mode 3, spi_sclk idles high. The LOW phase of every bit
//               still drives sclk low, so cycle timing is identical.
//
// Parameters
//   DATA_W   bits per word (>= 2)
//   CLK_DIV  clk cycles per sclk half period (>= 1)
//
// Ports
//   clk, rst_n          system clock, asynchronous active-low reset
//   tx_data/tx_last     word to send and end-of-burst flag
//   tx_valid/tx_ready   word handshake, accepted when both are high
//   rx_data/rx_valid    received word, rx_valid is a one-cycle pulse
//   busy                high whenever a transfer/hold/guard is in progress
//   spi_cs              chip select, active low
//   spi_sclk            serial clock
//   spi_mosi/spi_miso   serial data out / in
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module spi_host_master #(
  parameter int DATA_W  = 8,
  parameter int CLK_DIV = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  input  logic              tx_last,
  output logic              tx_ready,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  output logic              busy,
  output logic              spi_cs,
  output logic              spi_sclk,
  output logic              spi_mosi,
  input  logic              spi_miso
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int BIT_W = $clog2(DATA_W);
  localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(CLK_DIV - 1);
  localparam logic [BIT_W-1:0] BIT_MAX = BIT_W'(DATA_W - 1);

`ifdef KSTEP_SPI_MODE3_EN
  localparam logic SCLK_IDLE = 1'b1;
`else
  localparam logic SCLK_IDLE = 1'b0;
`endif

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOW   = 3'd1,
    HIGH  = 3'd2,
    WAIT  = 3'd3,
    HOLD  = 3'd4,
    GUARD = 3'd5
  } state_t;

  state_t              state_q;
  state_t              state_d;
  logic [DIV_W-1:0]    div_cnt_q;
  logic [BIT_W-1:0]    bit_cnt_q;
  logic [DATA_W-1:0]   tx_sr_q;
  logic [DATA_W-1:0]   rx_sr_q;
  logic [DATA_W-1:0]   rx_data_q;
  logic                rx_valid_q;
  logic                last_q;
  logic                cs_q;
  logic                sclk_q;
  logic                ready_q;

  logic                accept;
  logic                div_done;
  logic                last_bit;
  logic                sample;
  logic                bit_end;

  // Chip select is low from the first LOW phase until the hold time ends.
  function automatic logic cs_level(input state_t s);
    return !(s == LOW || s == HIGH || s == WAIT || s == HOLD);
  endfunction

  // Only the bit phases drive sclk away from its idle level (mode 0), or
  // only LOW pulls it down from the idle-high level (mode 3).
  function automatic logic sclk_level(input state_t s);
`ifdef KSTEP_SPI_MODE3_EN
    return (s != LOW);
`else
    return (s == HIGH);
`endif
  endfunction

  function automatic logic ready_level(input state_t s);
    return (s == IDLE || s == WAIT);
  endfunction

  assign accept   = tx_valid & ready_q;
  assign div_done = (div_cnt_q == DIV_MAX);
  assign last_bit = (bit_cnt_q == BIT_MAX);
  assign sample   = (state_q == LOW)  && div_done;
  assign bit_end  = (state_q == HIGH) && div_done;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept)   state_d = LOW;
      LOW:     if (div_done) state_d = HIGH;
      HIGH: begin
        if (div_done) begin
          if (!last_bit)   state_d = LOW;
          else if (last_q) state_d = HOLD;
          else             state_d = WAIT;
        end
      end
      WAIT:    if (accept)   state_d = LOW;
      HOLD:    if (div_done) state_d = GUARD;
      GUARD:   if (div_done) state_d = IDLE;
      default:               state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Timing counters, shift registers and registered SPI pins. The pins are
  // registered from the next state so they change cleanly on a clk edge and
  // line up with the state they belong to.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt_q  <= '0;
      bit_cnt_q  <= '0;
      tx_sr_q    <= '0;
      rx_sr_q    <= '0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      last_q     <= 1'b0;
      cs_q       <= 1'b1;
      sclk_q     <= SCLK_IDLE;
      ready_q    <= 1'b0;
    end else begin
      rx_valid_q <= 1'b0;

      // Each timed state starts counting from zero on entry.
      if (state_d != state_q || state_q == IDLE || state_q == WAIT) begin
        div_cnt_q <= '0;
      end else begin
        div_cnt_q <= div_cnt_q + DIV_W'(1);
      end

      if (accept) begin
        tx_sr_q   <= tx_data;
        last_q    <= tx_last;
        bit_cnt_q <= '0;
      end else if (bit_end && !last_bit) begin
        // After the final bit the register is left alone so mosi keeps the
        // last bit while waiting for the next word.
        tx_sr_q   <= {tx_sr_q[DATA_W-2:0], 1'b0};
        bit_cnt_q <= bit_cnt_q + BIT_W'(1);
      end

      if (sample) begin
        rx_sr_q <= {rx_sr_q[DATA_W-2:0], spi_miso};
      end

      if (bit_end && last_bit) begin
        rx_valid_q <= 1'b1;
        rx_data_q  <= rx_sr_q;
      end

      cs_q    <= cs_level(state_d);
      sclk_q  <= sclk_level(state_d);
      ready_q <= ready_level(state_d);
    end
  end

  assign tx_ready = ready_q;
  assign rx_data  = rx_data_q;
  assign rx_valid = rx_valid_q;
  assign busy     = (state_q != IDLE);
  assign spi_cs   = cs_q;
  assign spi_sclk = sclk_q;
  assign spi_mosi = tx_sr_q[DATA_W-1];

endmodule

// File: tb/tb_spi_host_master.sv
// -----------------------------------------------------------------------------
// tb_spi_host_master
//
// Bench for spi_host_master. A behavioural SPI slave (mode 0 or mode 3,
// following KSTEP_SPI_MODE3_EN) returns scripted miso words and collects
// the words seen on mosi. Expected rx words, expected slave words and the
// word latency are held in scoreboard queues. A second instance with
// CLK_DIV=1 and miso looped back to mosi covers the fastest divider.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_spi_host_master;

  localparam int DW       = 8;
  localparam int CD       = 2;
  localparam int WORD_CYC = 2 * CD * DW;
`ifdef KSTEP_SPI_MODE3_EN
  localparam logic SCLK_IDLE = 1'b1;
  localparam bit   MODE3     = 1'b1;
`else
  localparam logic SCLK_IDLE = 1'b0;
  localparam bit   MODE3     = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [DW-1:0] tx_data = '0;
  logic          tx_valid = 1'b0;
  logic          tx_last = 1'b0;
  logic          tx_ready;
  logic [DW-1:0] rx_data;
  logic          rx_valid;
  logic          busy;
  logic          spi_cs;
  logic          spi_sclk;
  logic          spi_mosi;
  logic          spi_miso = 1'b0;

  logic [DW-1:0] d1_tx_data = '0;
  logic          d1_tx_valid = 1'b0;
  logic          d1_tx_last = 1'b0;
  logic          d1_tx_ready;
  logic [DW-1:0] d1_rx_data;
  logic          d1_rx_valid;
  logic          d1_busy;
  logic          d1_cs;
  logic          d1_sclk;
  logic          d1_mosi;

  always #5 clk = ~clk;

  spi_host_master #(.DATA_W(DW), .CLK_DIV(CD)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_last(tx_last), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .busy(busy),
    .spi_cs(spi_cs), .spi_sclk(spi_sclk), .spi_mosi(spi_mosi), .spi_miso(spi_miso)
  );

  spi_host_master #(.DATA_W(DW), .CLK_DIV(1)) u_dut_div1 (
    .clk(clk), .rst_n(rst_n),
    .tx_data(d1_tx_data), .tx_valid(d1_tx_valid), .tx_last(d1_tx_last), .tx_ready(d1_tx_ready),
    .rx_data(d1_rx_data), .rx_valid(d1_rx_valid), .busy(d1_busy),
    .spi_cs(d1_cs), .spi_sclk(d1_sclk), .spi_mosi(d1_mosi), .spi_miso(d1_mosi)
  );

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Scoreboard queues.
  logic [DW-1:0] miso_q[$];
  logic [DW-1:0] exp_tx_q[$];
  logic [DW-1:0] exp_rx_q[$];
  int            acc_q[$];
  int            rx_cnt = 0;
  int            overlap_cnt = 0;
  int            sclk_rises = 0;
  int            cs_rises = 0;

  // Output monitor: sampled 1ns after the falling edge, well away from the
  // active edge and after the driver's negedge updates.
  always begin
    @(negedge clk);
    #1;
    if (!rst_n) begin
      acc_q.delete();
    end
    if (rx_valid) begin
      rx_cnt++;
      if (exp_rx_q.size() == 0) begin
        check("rx_valid_unexpected", rx_valid, 1'b0);
      end else begin
        check("rx_data", rx_data, exp_rx_q.pop_front());
      end
      if (acc_q.size() != 0) begin
        check("rx_latency", cyc - acc_q.pop_front() + 1, WORD_CYC + 1);
      end
      check("sclk_idle_after_word", spi_sclk, SCLK_IDLE);
    end
    if (rst_n && tx_valid && tx_ready) begin
      if (rx_valid) overlap_cnt++;
      acc_q.push_back(cyc + 1);
    end
  end

  // Behavioural SPI slave. Mode 0 presents the MSB when cs falls; mode 3
  // presents each bit on the falling sclk edge that opens the bit. Both
  // sample mosi on the rising edge. A word is retired once all bits are
  // captured; a word cut short by cs rising is discarded.
  logic [DW-1:0] slv_word = '0;
  logic [DW-1:0] slv_rx = '0;
  int            slv_idx = -1;
  int            slv_cnt = 0;
  logic          prev_cs = 1'b1;
  logic          prev_sclk = SCLK_IDLE;

  task automatic slv_load();
    slv_word = (miso_q.size() != 0) ? miso_q[0] : '0;
    spi_miso = slv_word[DW-1];
    slv_idx  = DW - 2;
  endtask

  always @(spi_cs or spi_sclk) begin
    if (prev_cs === 1'b0 && spi_cs === 1'b1) begin
      cs_rises++;
      if (slv_cnt != 0 && miso_q.size() != 0) void'(miso_q.pop_front());
      slv_cnt = 0;
      slv_idx = -1;
    end
    if (rst_n && spi_cs === 1'b0) begin
      if (prev_cs !== 1'b0 && !MODE3) begin
        slv_load();
      end else if (prev_sclk === 1'b1 && spi_sclk === 1'b0) begin
        if (slv_idx < 0) begin
          slv_load();
        end else begin
          spi_miso = slv_word[slv_idx];
          slv_idx--;
        end
      end
      if (prev_sclk === 1'b0 && spi_sclk === 1'b1) begin
        sclk_rises++;
        slv_rx = {slv_rx[DW-2:0], spi_mosi};
        slv_cnt++;
        if (slv_cnt == DW) begin
          slv_cnt = 0;
          if (miso_q.size() != 0) void'(miso_q.pop_front());
          if (exp_tx_q.size() != 0) begin
            check("slave_rx", slv_rx, exp_tx_q.pop_front());
          end else begin
            n_chk++;
            n_fail++;
            $display("FAIL slave_rx_unexpected: got 0x%0h, expected no word", slv_rx);
          end
        end
      end
    end
    prev_cs   = spi_cs;
    prev_sclk = spi_sclk;
  end

  // Drive one word; called at a falling edge, returns at the falling edge
  // after the accepting edge with tx_valid dropped.
  task automatic send(input logic [DW-1:0] d, input logic l, input logic [DW-1:0] m,
                      input logic [DW-1:0] erx, input logic [DW-1:0] etx);
    miso_q.push_back(m);
    exp_rx_q.push_back(erx);
    exp_tx_q.push_back(etx);
    tx_data  = d;
    tx_last  = l;
    tx_valid = 1'b1;
    for (int i = 0; i < 400 && !tx_ready; i++) @(negedge clk);
    if (!tx_ready) check("tx_ready_timeout", tx_ready, 1'b1);
    @(posedge clk);
    @(negedge clk);
    tx_valid = 1'b0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 400 && (busy || !tx_ready); i++) @(negedge clk);
    check("return_to_idle", busy, 1'b0);
  endtask

  // Cycle-exact cs / tx_ready shape of a single last-flagged word. Entered
  // in cycle accept+1.
  task automatic frame_timing(input logic first_bit);
    for (int k = 1; k <= WORD_CYC + 2 * CD + 1; k++) begin
      if (k > 1) @(negedge clk);
      #1;
      if (k == 1) begin
        check("cs_low_after_accept", spi_cs, 1'b0);
        check("mosi_first_bit", spi_mosi, first_bit);
        check("sclk_low_first_phase", spi_sclk, 1'b0);
      end
      if (k == WORD_CYC + CD)         check("cs_low_end_of_hold", spi_cs, 1'b0);
      if (k == WORD_CYC + CD + 1) begin
        check("cs_high_guard", spi_cs, 1'b1);
        check("tx_ready_low_guard", tx_ready, 1'b0);
      end
      if (k == WORD_CYC + 2 * CD)     check("tx_ready_low_guard_end", tx_ready, 1'b0);
      if (k == WORD_CYC + 2 * CD + 1) check("tx_ready_back", tx_ready, 1'b1);
    end
  endtask

  typedef struct {
    logic [DW-1:0] tx;
    logic [DW-1:0] miso;
    logic [DW-1:0] exp_rx;
    logic [DW-1:0] exp_slave;
  } vec_t;

  vec_t vecs[5];

  initial begin
    int s0, c0, r0, o0;
    logic [DW-1:0] cap;

    vecs[0] = '{tx: 8'hA5, miso: 8'h3C, exp_rx: 8'h3C, exp_slave: 8'hA5};
    vecs[1] = '{tx: 8'h00, miso: 8'hFF, exp_rx: 8'hFF, exp_slave: 8'h00};
    vecs[2] = '{tx: 8'hFF, miso: 8'h00, exp_rx: 8'h00, exp_slave: 8'hFF};
    vecs[3] = '{tx: 8'h81, miso: 8'h7E, exp_rx: 8'h7E, exp_slave: 8'h81};
    vecs[4] = '{tx: 8'h5A, miso: 8'hC3, exp_rx: 8'hC3, exp_slave: 8'h5A};

    // Reset values.
    repeat (3) @(negedge clk);
    #1;
    check("rst_cs", spi_cs, 1'b1);
    check("rst_sclk", spi_sclk, SCLK_IDLE);
    check("rst_mosi", spi_mosi, 1'b0);
    check("rst_tx_ready", tx_ready, 1'b0);
    check("rst_rx_valid", rx_valid, 1'b0);
    check("rst_rx_data", rx_data, '0);
    check("rst_busy", busy, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    check("ready_after_reset", tx_ready, 1'b1);

    // Single last-flagged words from the table.
    for (int i = 0; i < 5; i++) begin
      send(vecs[i].tx, 1'b1, vecs[i].miso, vecs[i].exp_rx, vecs[i].exp_slave);
      if (i == 0) frame_timing(vecs[i].tx[DW-1]);
      wait_idle();
    end

    // Burst of two words under one chip select.
    s0 = sclk_rises; c0 = cs_rises; r0 = rx_cnt; o0 = overlap_cnt;
    send(8'h12, 1'b0, 8'hA1, 8'hA1, 8'h12);
    send(8'h34, 1'b1, 8'hB2, 8'hB2, 8'h34);
    wait_idle();
    check("burst_sclk_pulses", sclk_rises - s0, 2 * DW);
    check("burst_cs_rises", cs_rises - c0, 1);
    check("burst_rx_pulses", rx_cnt - r0, 2);
    check("burst_accept_in_rx_cycle", overlap_cnt - o0, 1);

    // Backpressure: tx_valid held while busy; data changed before ready.
    r0 = rx_cnt;
    send(8'h11, 1'b1, 8'h0F, 8'h0F, 8'h11);
    tx_data = 8'h22; tx_last = 1'b1; tx_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      #1;
      check("bp_ready_low", tx_ready, 1'b0);
    end
    send(8'hFF, 1'b1, 8'hE7, 8'hE7, 8'hFF);
    wait_idle();
    check("bp_word_count", rx_cnt - r0, 2);
    check("bp_slave_queue_empty", exp_tx_q.size(), 0);

    // Reset in the middle of a word.
    r0 = rx_cnt;
    s0 = sclk_rises;
    miso_q.push_back(8'h55);
    tx_data = 8'hC3; tx_last = 1'b1; tx_valid = 1'b1;
    for (int i = 0; i < 50 && !tx_ready; i++) @(negedge clk);
    @(posedge clk);
    @(negedge clk);
    tx_valid = 1'b0;
    for (int i = 0; i < 200 && (sclk_rises - s0) < 3; i++) @(negedge clk);
    check("third_sclk_rise_seen", sclk_rises - s0, 3);
    #2;
    rst_n = 1'b0;
    #1;
    check("abort_cs", spi_cs, 1'b1);
    check("abort_sclk", spi_sclk, SCLK_IDLE);
    check("abort_mosi", spi_mosi, 1'b0);
    check("abort_busy", busy, 1'b0);
    check("abort_tx_ready", tx_ready, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
      check("abort_no_rx_valid", rx_valid, 1'b0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("abort_no_rx_count", rx_cnt - r0, 0);
    send(8'h96, 1'b1, 8'h69, 8'h69, 8'h96);
    wait_idle();

    // CLK_DIV=1 instance, miso looped back to mosi.
    d1_tx_data = 8'h81; d1_tx_last = 1'b1; d1_tx_valid = 1'b1;
    for (int i = 0; i < 50 && !d1_tx_ready; i++) @(negedge clk);
    check("d1_ready", d1_tx_ready, 1'b1);
    @(posedge clk);
    @(negedge clk);
    d1_tx_valid = 1'b0;
    cap = '0;
    for (int k = 1; k <= 2 * DW + 2; k++) begin
      if (k > 1) @(negedge clk);
      #1;
      if (k <= 2 * DW) begin
        check("d1_sclk_toggle", d1_sclk, (k % 2) == 0);
        check("d1_cs_low", d1_cs, 1'b0);
      end
      if (k <= 2 * DW && (k % 2) == 0) cap = {cap[DW-2:0], d1_mosi};
      check("d1_rx_valid_timing", d1_rx_valid, k == 2 * DW + 1);
      if (k == 2 * DW + 1) check("d1_rx_data", d1_rx_data, 8'h81);
    end
    check("d1_mosi_word", cap, 8'h81);

    repeat (4) @(negedge clk);
    check("final_exp_rx_empty", exp_rx_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
